// File: rtl/act_lut_arbiter.sv
// act_lut_arbiter: round-robin sharing of the activation LUT ROM.
// Define ACT_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module act_lut_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int SUM_W   = 26,
   parameter int SHIFT   = 0,
   parameter int ID_W    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*SUM_W-1:0] req_sum,
   output logic [NUM_REQ-1:0]       ack,
   output logic [10:0]              lut_addr,
   input  logic [7:0]               lut_q,
   output logic                     rsp_valid,
   output logic [ID_W-1:0]          rsp_id,
   output logic [7:0]               rsp_data,
   output logic                     busy
);

   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(1023);
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-1024);

   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [10:0]        addr_q, addr_d;
   logic               v1_q, v2_q;
   logic [ID_W-1:0]    id1_q, id1_d, id2_q;
   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [7:0]         rsp_data_q;

   logic [NUM_REQ-1:0] elig;
   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [SUM_W-1:0]   win_sum;

   // Scale, clamp to [-1024,1023], then offset-binary by flipping the MSB.
   function automatic logic [10:0] to_addr(input logic [SUM_W-1:0] raw);
      logic signed [SUM_W-1:0] s;
      logic [10:0]             a;
      s = $signed(raw) >>> SHIFT;
      if (s > SAT_HI) begin
         a = 11'h7FF;
      end else if (s < SAT_LO) begin
         a = 11'h000;
      end else begin
         a = {~s[10], s[9:0]};
      end
      return a;
   endfunction

   // A requester being acked this cycle is not eligible again until next cycle.
   assign elig = req & ~ack_q;

`ifdef ACT_ARB_FIXED_PRIO_EN
   // Lowest eligible index wins.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && elig[k]) begin
            win_found = 1'b1;
            win_id    = ID_W'(k);
            win_sum   = req_sum[k*SUM_W +: SUM_W];
         end
      end
   end
`else
   logic [ID_W-1:0] ptr_q, ptr_d;

   // Search starts after the last winner and wraps around.
   always_comb begin
      int j;
      win_found = 1'b0;
      win_id    = '0;
      win_sum   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = (int'(ptr_q) + k) % NUM_REQ;
         if (!win_found && elig[j]) begin
            win_found = 1'b1;
            win_id    = ID_W'(j);
            win_sum   = req_sum[j*SUM_W +: SUM_W];
         end
      end
   end

   assign ptr_d = win_found ? win_id : ptr_q;

   // Round-robin pointer remembers the most recent winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= ID_W'(NUM_REQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Grant-stage next-state: one-hot ack, address and tag for the winner.
   always_comb begin
      ack_d  = '0;
      addr_d = addr_q;
      id1_d  = id1_q;
      if (win_found) begin
         ack_d[win_id] = 1'b1;
         addr_d        = to_addr(win_sum);
         id1_d         = win_id;
      end
   end

   // Stage 1: grant registers and ROM address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_q  <= '0;
         addr_q <= 11'h400;
         v1_q   <= 1'b0;
         id1_q  <= '0;
      end else begin
         ack_q  <= ack_d;
         addr_q <= addr_d;
         v1_q   <= win_found;
         id1_q  <= id1_d;
      end
   end

   // Stage 2: tag follows the ROM's own registered read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q  <= 1'b0;
         id2_q <= '0;
      end else begin
         v2_q  <= v1_q;
         id2_q <= id1_q;
      end
   end

   // Stage 3: capture the ROM byte only for a real lookup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= v2_q;
         rsp_id_q    <= id2_q;
         if (v2_q) begin
            rsp_data_q <= lut_q;
         end
      end
   end

   assign ack       = ack_q;
   assign lut_addr  = addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = v1_q | v2_q | rsp_valid_q;

endmodule

// File: tb/tb_act_lut_arbiter.sv
// tb_act_lut_arbiter: directed and random checks against a cycle model.
// Define ACT_ARB_FIXED_PRIO_EN to exercise fixed priority with 3 requesters.
module tb_act_lut_arbiter;

`ifdef ACT_ARB_FIXED_PRIO_EN
   localparam int N   = 3;
   localparam int IDW = 2;
`else
   localparam int N   = 2;
   localparam int IDW = 1;
`endif
   localparam int SW    = 26;
   localparam int SHIFT = 0;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*SW-1:0] req_sum;
   logic [N-1:0]    ack;
   logic [10:0]     lut_addr;
   logic [7:0]      lut_q;
   logic            rsp_valid;
   logic [IDW-1:0]  rsp_id;
   logic [7:0]      rsp_data;
   logic            busy;

   logic signed [SW-1:0] sums [N];
   logic [7:0]           rom [0:2047];

   int checks = 0;
   int fails  = 0;

   // model state
   int ptr;
   int last_ack;
   int laddr;
   int n;
   bit gv    [0:1023];
   int gid   [0:1023];
   int gaddr [0:1023];

   always #5 clk = ~clk;

   always_comb begin
      req_sum = '0;
      for (int i = 0; i < N; i++) req_sum[i*SW +: SW] = sums[i];
   end

   always @(posedge clk) lut_q <= rom[lut_addr];

   act_lut_arbiter #(
      .NUM_REQ(N), .SUM_W(SW), .SHIFT(SHIFT), .ID_W(IDW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_sum(req_sum),
      .ack(ack), .lut_addr(lut_addr), .lut_q(lut_q),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_addr(input logic signed [SW-1:0] v);
      int s;
      s = int'(v) >>> SHIFT;
      if (s > 1023) s = 1023;
      if (s < -1024) s = -1024;
      return s + 1024;
   endfunction

   function automatic logic signed [SW-1:0] rand_sum();
      int pick [5];
      pick = '{1023, 1024, -1024, -1025, 0};
      case ($urandom_range(0, 2))
         0: return SW'(int'($urandom_range(0, 2200)) - 1100);
         1: return SW'($urandom);
         default: return SW'(pick[$urandom_range(0, 4)]);
      endcase
   endfunction

   task automatic step();
      int g;
      int e;
      g = -1;
`ifdef ACT_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++)
         if (g < 0 && req[i] && last_ack != i) g = i;
`else
      for (int k = 1; k <= N; k++) begin
         e = (ptr + k) % N;
         if (g < 0 && req[e] && last_ack != e) g = e;
      end
`endif
      @(posedge clk);
      #1;
      n++;
      gv[n]  = (g >= 0);
      gid[n] = g;
      if (g >= 0) begin
         laddr = exp_addr(sums[g]);
         ptr   = g;
      end
      gaddr[n] = laddr;
      last_ack = g;
      chk("ack", 32'(ack), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("lut_addr", 32'(lut_addr), laddr);
      chk("rsp_valid", 32'(rsp_valid), 32'(gv[n-2]));
      if (gv[n-2]) begin
         chk("rsp_id", 32'(rsp_id), gid[n-2]);
         chk("rsp_data", 32'(rsp_data), 32'(rom[gaddr[n-2]]));
      end
      chk("busy", 32'(busy), 32'(gv[n] | gv[n-1] | gv[n-2]));
   endtask

   task automatic reset_checks();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_lut_addr", 32'(lut_addr), 32'h400);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_busy", 32'(busy), 0);
   endtask

   task automatic finish_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      gv[n]    = 1'b0;
      gv[n-1]  = 1'b0;
      ptr      = N - 1;
      last_ack = -1;
      laddr    = 32'h400;
   endtask

   initial begin
      int sat_in  [5];
      int sat_exp [5];
      sat_in  = '{5000, -2000, -1, 1023, -1024};
      sat_exp = '{32'h7FF, 32'h000, 32'h3FF, 32'h7FF, 32'h000};
      for (int a = 0; a < 2048; a++) rom[a] = 8'($urandom);
      rom[11'h400] = 8'h80;
      for (int i = 0; i < 1024; i++) begin
         gv[i] = 1'b0; gid[i] = 0; gaddr[i] = 0;
      end
      n = 2;
      req = '0;
      for (int i = 0; i < N; i++) sums[i] = '0;

      // power-on reset
      rst_n = 1'b0;
      #12;
      reset_checks();
      finish_reset();

      // single lookup of zero
      req[0] = 1'b1;
      step();
      chk("t1_addr", 32'(lut_addr), 32'h400);
      req = '0;
      step();
      step();
      chk("t1_data", 32'(rsp_data), 32'h80);
      step();
      chk("t1_busy", 32'(busy), 0);

      // saturation table
      for (int t = 0; t < 5; t++) begin
         sums[0] = SW'(sat_in[t]);
         req[0]  = 1'b1;
         step();
         chk("sat_addr", 32'(lut_addr), sat_exp[t]);
         req = '0;
         step();
      end
      repeat (3) step();

      // two requesters held together
      sums[0] = SW'(100);
      sums[1] = SW'(-300);
      req[1:0] = 2'b11;
      repeat (8) step();
      req = '0;
      repeat (3) step();
      chk("drain_busy", 32'(busy), 0);

      // single requester held
      sums[1] = SW'(777);
      req[1] = 1'b1;
      repeat (6) step();
      req = '0;
      repeat (3) step();

      // reset one cycle after a grant
      sums[0] = SW'(500);
      req[0] = 1'b1;
      step();
      req = '0;
      #2;
      rst_n = 1'b0;
      #1;
      reset_checks();
      finish_reset();
      req[1:0] = 2'b11;
      step();
      chk("post_rst_ack0", 32'(ack[0]), 1);
      req = '0;
      repeat (3) step();

`ifdef ACT_ARB_FIXED_PRIO_EN
      // fixed priority: requester 1 preferred over 2
      sums[1] = SW'(10);
      sums[2] = SW'(-10);
      req = 3'b110;
      step();
      chk("fp_ack0", 32'(ack), 32'b010);
      step();
      chk("fp_ack1", 32'(ack), 32'b100);
      step();
      chk("fp_ack2", 32'(ack), 32'b010);
      req = '0;
      repeat (3) step();
`endif

      // random traffic; sums held while a request is pending
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] || last_ack == i) begin
               req[i]  = 1'($urandom_range(0, 1));
               sums[i] = rand_sum();
            end
         end
         step();
      end
      req = '0;
      repeat (4) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/act_lut_arbiter.md
Name: act_lut_arbiter

Overview:
- Shares the single synchronous activation-function LUT ROM (11-bit address, 8-bit data, 1-cycle registered read) between NUM_REQ neuron-layer requesters (default: hidden layer and output layer).
- Round-robin arbitration; converts each winner's signed MAC sum to a saturated, offset-binary LUT address.
- Tracks the ROM read latency and returns the activation byte tagged with the requester ID.
- Sits between the neuron MAC units and the LUT ROM instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SUM_W, 26, width of each signed MAC sum.
- SHIFT, 0, arithmetic right shift applied to the sum before saturation (0..SUM_W-11).
- ID_W, 1, requester ID width; the instantiator sets it to max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_sum  in  NUM_REQ*SUM_W  packed signed sums; requester i occupies bits [i*SUM_W +: SUM_W]. Held stable while req[i]=1.
- ack  out  NUM_REQ  registered one-hot grant pulse.
- lut_addr  out  11  registered address to ROM addr.
- lut_q  in  8  ROM q.
- rsp_valid  out  1  registered result strobe.
- rsp_id  out  ID_W  requester index of the result.
- rsp_data  out  8  registered activation value.
- busy  out  1  high when any lookup is in flight (pipeline valid bit set).

Behaviour:
- Reset values: ack=0, lut_addr=11'h400, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, RR pointer=NUM_REQ-1 (requester 0 wins first), both pipeline valid bits=0.
- Eligibility: req[i]=1 and ack[i]=0. The ack-high cycle is never re-granted, so one request costs the requester at least 2 cycles.
- A req still high after the ack cycle is a new request.
- Arbitration is combinational. The search starts at pointer+1 and wraps modulo NUM_REQ. The first eligible requester wins.
- At the edge where requester i is granted:
  - ack[i]<=1 (one cycle only);
  - lut_addr<=addr(req_sum[i]);
  - v1<=1, id1<=i;
  - pointer<=i.
- With no eligible requester: ack<=0, v1<=0, lut_addr holds.
- Stage 2 (next edge): v2<=v1, id2<=id1. The ROM registers q in the same edge.
- Stage 3 (next edge): rsp_valid<=v2, rsp_id<=id2, rsp_data<=lut_q (captured only when v2=1, otherwise held).
- Latency: rsp_valid rises exactly 2 cycles after the corresponding ack is seen high.
- Throughput: one lookup per cycle when at least 2 requesters alternate. Results return in grant order.
- busy = v1 | v2 | rsp_valid.
- Address conversion:
  - s = req_sum >>> SHIFT (arithmetic);
  - sat = clamp(s, -1024, +1023);
  - lut_addr = sat[10:0] with MSB inverted (i.e. sat + 1024).
  - So 0 maps to 0x400, +1023 and above to 0x7FF, -1024 and below to 0x000.
- Boundary conditions:
  - Single requester holding req continuously: granted every other cycle.
  - All req low: pipeline drains and busy falls 3 cycles after the last grant.
  - rst_n low mid-operation: all in-flight lookups are discarded with no rsp_valid, and the pointer resets. A requester whose ack was lost must re-request.

Optional Feature:
- Macro ACT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest eligible index wins, and the pointer is unused. The ack-blocking rule still applies.
- Undefined (default): round-robin as above.

Test Plan:
- Reset then req=2'b01, req_sum[0]=0:
  - ack=01 in cycle 1, lut_addr=0x400;
  - ROM preloaded rom[0x400]=0x80, so rsp_valid=1, rsp_id=0, rsp_data=0x80 two cycles after ack;
  - busy returns to 0.
- Saturation, one request each, SHIFT=0:
  - sums 5000, -2000, -1, 1023, -1024 give lut_addr 0x7FF, 0x000, 0x3FF, 0x7FF, 0x000 respectively.
- Both req held high 8 cycles with distinct sums:
  - ack sequence 01,10,01,10,...;
  - rsp_id sequence 0,1,0,1 lagging by 2 cycles;
  - rsp_valid continuous after fill.
- Only req[1] held high 6 cycles: ack[1] pulses on alternate cycles (3 grants) and rsp_valid alternates.
- Assert rst_n=0 one cycle after a grant: rsp_valid never rises for that lookup; outputs equal reset values immediately (asynchronously); next grant goes to requester 0 if both request.
- With ACT_ARB_FIXED_PRIO_EN and NUM_REQ=3, req=3'b110 held: ack alternates 010,100,010 (requester 1 preferred whenever eligible).
